// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants and types for the fetch queue unit and its predecoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: RISC-V control-flow opcodes, default queue depth, static
// prediction mode codes, fetch FSM state type and the queue entry record.
package fetch_queue_unit_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int FQ_DEPTH_DEFAULT = 8;

  // Static branch-prediction modes.
  localparam int PRED_NT   = 0;  // always not-taken
  localparam int PRED_BTFN = 1;  // backward taken, forward not taken

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_STALL = 1'b1
  } fq_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } fq_entry_t;

endpackage

// File: rtl/fetch_predecode.sv
// Predecoder: derives the next fetch PC and static prediction from one word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle on the word being accepted.
//
// Ports: inst/pc = fetched word and its address; next_pc = address to fetch
// next; pred = predicted taken (JAL or backward branch in BTFN mode);
// is_jalr = word is a JALR, so fetch must stop until the target resolves.
module fetch_predecode
  import fetch_queue_unit_pkg::*;
#(
  parameter int PRED_MODE = PRED_BTFN
) (
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pred,
  output logic        is_jalr
);

  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] pc_seq;

  assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign pc_seq = pc + 32'd4;

  always_comb begin
    next_pc = pc_seq;
    pred    = 1'b0;
    is_jalr = 1'b0;
    case (inst[6:0])
      OPC_JAL: begin
        next_pc = pc + imm_j;
        pred    = 1'b1;
      end
      OPC_BRANCH: begin
        // inst[31] is the B-immediate sign bit: set means a backward target.
        if (PRED_MODE == PRED_BTFN && inst[31]) begin
          next_pc = pc + imm_b;
          pred    = 1'b1;
        end
      end
      OPC_JALR: begin
        is_jalr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: prefetches into a DEPTH-entry queue ahead of issue.
// Latency: fetched word visible at deq_* the cycle after inst_ready; deq_* are combinational from the head.
// Backpressure: inst_req drops when full or stalled on JALR; rdy_in low freezes every register.
//
// Ports: clk_in/rst_n_in clock and async active-low reset; rdy_in global pause;
// inst_req/pc_out/inst_ready/inst icache request and response;
// deq_valid/deq_inst/deq_pc/deq_pred/deq_ready head of queue to the decoder;
// clear/clear_pc ROB flush redirect; stall_end/jalr_addr JALR resolution;
// stall_out high while waiting on a JALR; count_out queue occupancy.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int          DEPTH     = FQ_DEPTH_DEFAULT,
  parameter int          PTR_BIT   = 3,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          PRED_MODE = PRED_BTFN
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  output logic               inst_req,
  output logic [31:0]        pc_out,
  input  logic               inst_ready,
  input  logic [31:0]        inst,
  output logic               deq_valid,
  output logic [31:0]        deq_inst,
  output logic [31:0]        deq_pc,
  output logic               deq_pred,
  input  logic               deq_ready,
  input  logic               clear,
  input  logic [31:0]        clear_pc,
  input  logic               stall_end,
  input  logic [31:0]        jalr_addr,
  output logic               stall_out,
  output logic [PTR_BIT:0]   count_out
);

  localparam logic [PTR_BIT:0] CNT_FULL = (PTR_BIT + 1)'(DEPTH);

  fq_state_t          state;
  logic [31:0]        pc;
  logic [PTR_BIT-1:0] head;
  logic [PTR_BIT-1:0] tail;
  logic [PTR_BIT:0]   count;
  fq_entry_t          mem [DEPTH];

  logic [31:0] pd_next_pc;
  logic        pd_pred;
  logic        pd_is_jalr;
  logic        flush;
  logic        enq;
  logic        deq;

  fetch_predecode #(
    .PRED_MODE (PRED_MODE)
  ) u_predecode (
    .inst    (inst),
    .pc      (pc),
    .next_pc (pd_next_pc),
    .pred    (pd_pred),
    .is_jalr (pd_is_jalr)
  );

  // Request depends only on registered state so the icache never sees a
  // combinational path from the consumer's deq_ready.
  assign inst_req  = (state == ST_FETCH) && (count != CNT_FULL);
  assign pc_out    = pc;
  assign stall_out = (state == ST_STALL);
  assign count_out = count;

  assign deq_valid = (count != '0);
  assign deq_inst  = mem[head].inst;
  assign deq_pc    = mem[head].pc;
  assign deq_pred  = mem[head].pred;

  // A flush swallows any same-cycle response, dequeue and stall_end.
  assign flush = rdy_in && clear;
  assign enq   = rdy_in && inst_req && inst_ready && !clear;
  assign deq   = rdy_in && deq_valid && deq_ready && !clear;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      state <= ST_FETCH;
      pc    <= clear_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (enq) begin
        tail <= tail + PTR_BIT'(1);
        pc   <= pd_next_pc;
        if (pd_is_jalr) begin
          state <= ST_STALL;
        end
      end else if (state == ST_STALL && stall_end) begin
        // enq is impossible while stalled, so this branch never competes with it.
        pc    <= jalr_addr;
        state <= ST_FETCH;
      end
      if (deq) begin
        head <= head + PTR_BIT'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PTR_BIT + 1)'(1);
        2'b01:   count <= count - (PTR_BIT + 1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: deq_valid masks entries outside head..tail.
  always_ff @(posedge clk_in) begin
    if (enq) begin
      mem[tail] <= '{inst: inst, pc: pc, pred: pd_pred};
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] JALR = 32'h00008067;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        inst_ready;
  logic [31:0] inst;
  logic        deq_ready;
  logic        clear;
  logic [31:0] clear_pc;
  logic        stall_end;
  logic [31:0] jalr_addr;

  logic        inst_req, deq_valid, deq_pred, stall_out;
  logic [31:0] pc_out, deq_inst, deq_pc;
  logic [3:0]  count_out;

  logic        inst_req_nt, deq_valid_nt, deq_pred_nt, stall_out_nt;
  logic [31:0] pc_out_nt, deq_inst_nt, deq_pc_nt;
  logic [3:0]  count_out_nt;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  fetch_queue_unit #(.DEPTH(8), .PTR_BIT(3), .RESET_PC(32'h0), .PRED_MODE(1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .inst_req(inst_req), .pc_out(pc_out), .inst_ready(inst_ready), .inst(inst),
    .deq_valid(deq_valid), .deq_inst(deq_inst), .deq_pc(deq_pc), .deq_pred(deq_pred),
    .deq_ready(deq_ready), .clear(clear), .clear_pc(clear_pc),
    .stall_end(stall_end), .jalr_addr(jalr_addr),
    .stall_out(stall_out), .count_out(count_out));

  fetch_queue_unit #(.DEPTH(8), .PTR_BIT(3), .RESET_PC(32'h0), .PRED_MODE(0)) dut_nt (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .inst_req(inst_req_nt), .pc_out(pc_out_nt), .inst_ready(inst_ready), .inst(inst),
    .deq_valid(deq_valid_nt), .deq_inst(deq_inst_nt), .deq_pc(deq_pc_nt), .deq_pred(deq_pred_nt),
    .deq_ready(deq_ready), .clear(clear), .clear_pc(clear_pc),
    .stall_end(stall_end), .jalr_addr(jalr_addr),
    .stall_out(stall_out_nt), .count_out(count_out_nt));

  // ---------------- reference model (queue of fetched words) ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    bit          pred;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] m_pc;
  bit          m_stall;

  function automatic void ref_pd(input logic [31:0] pc, input logic [31:0] w, input bit btfn,
                                 output logic [31:0] nxt, output bit pr, output bit jl);
    int off;
    off = 4;
    pr  = 0;
    jl  = 0;
    case (w[6:0])
      7'h6F: begin
        off = int'({w[31], w[19:12], w[20], w[30:21], 1'b0});
        if (w[31]) off = off - (1 << 21);
        pr = 1;
      end
      7'h63: if (btfn && w[31]) begin
        off = int'({w[31], w[7], w[30:25], w[11:8], 1'b0}) - (1 << 13);
        pr  = 1;
      end
      7'h67: jl = 1;
      default: ;
    endcase
    nxt = pc + 32'(off);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("inst_req", 32'(inst_req), 32'(!m_stall && mq.size() != 8));
    chk("pc_out", pc_out, m_pc);
    chk("count_out", 32'(count_out), 32'(mq.size()));
    chk("deq_valid", 32'(deq_valid), 32'(mq.size() != 0));
    chk("stall_out", 32'(stall_out), 32'(m_stall));
    if (mq.size() != 0) begin
      chk("deq_inst", deq_inst, mq[0].inst);
      chk("deq_pc", deq_pc, mq[0].pc);
      chk("deq_pred", 32'(deq_pred), 32'(mq[0].pred));
    end
  endtask

  // Check current outputs against the model, advance the model by one clock
  // with the inputs now applied, then step the DUT to the next edge + 1.
  task automatic tick();
    bit          ireq;
    logic [31:0] nxt;
    bit          pr, jl;
    check_model();
    ireq = !m_stall && mq.size() != 8;
    if (rdy_in) begin
      if (clear) begin
        mq.delete();
        m_pc    = clear_pc;
        m_stall = 0;
      end else begin
        if (mq.size() != 0 && deq_ready) void'(mq.pop_front());
        if (ireq && inst_ready) begin
          ref_pd(m_pc, inst, 1'b1, nxt, pr, jl);
          mq.push_back('{inst: inst, pc: m_pc, pred: pr});
          m_pc = nxt;
          if (jl) m_stall = 1;
        end else if (m_stall && stall_end) begin
          m_pc    = jalr_addr;
          m_stall = 0;
        end
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1; inst_ready = 0; deq_ready = 0; clear = 0; stall_end = 0;
  endtask

  // ---------------- predecode vector table ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] nxt_bt;
    bit          pred_bt;
    logic [31:0] nxt_nt;
    bit          pred_nt;
    bit          stall;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{32'h0000_0000, ADDI,          32'h0000_0004, 0, 32'h0000_0004, 0, 0};
    vt[1] = '{32'h0000_0010, 32'h0200006F, 32'h0000_0030, 1, 32'h0000_0030, 1, 0}; // JAL +0x20
    vt[2] = '{32'h0000_0040, 32'hFE000CE3, 32'h0000_0038, 1, 32'h0000_0044, 0, 0}; // BEQ -8
    vt[3] = '{32'h0000_0038, 32'h00000463, 32'h0000_003C, 0, 32'h0000_003C, 0, 0}; // BEQ +8
    vt[4] = '{32'h0000_0100, JALR,          32'h0000_0104, 0, 32'h0000_0104, 0, 1};
    vt[5] = '{32'h0000_1000, 32'hFFDFF06F, 32'h0000_0FFC, 1, 32'h0000_0FFC, 1, 0}; // JAL -4
    vt[6] = '{32'h0000_0000, 32'hFE000CE3, 32'hFFFF_FFF8, 1, 32'h0000_0004, 0, 0}; // wraps below 0
    vt[7] = '{32'hFFFF_FFFC, ADDI,          32'h0000_0000, 0, 32'h0000_0000, 0, 0}; // wraps above max

    rst_n_in = 0; idle(); inst = ADDI; clear_pc = 0; jalr_addr = 0;
    mq.delete(); m_pc = 32'h0; m_stall = 0;

    // Reset state
    #3;
    chk("rst inst_req", 32'(inst_req), 32'd1);
    chk("rst pc_out", pc_out, 32'h0);
    chk("rst deq_valid", 32'(deq_valid), 32'd0);
    chk("rst stall_out", 32'(stall_out), 32'd0);
    chk("rst count_out", 32'(count_out), 32'd0);
    #9 rst_n_in = 1;
    @(posedge clk_in); #1;

    // Fill with ADDI, consumer blocked
    inst_ready = 1; inst = ADDI;
    for (int i = 0; i < 10; i++) tick();
    chk("fill count", 32'(count_out), 32'd8);
    chk("fill inst_req", 32'(inst_req), 32'd0);
    chk("fill pc_out", pc_out, 32'd32);
    chk("fill head pc", deq_pc, 32'd0);

    // Full with simultaneous dequeue: request returns the next cycle
    deq_ready = 1; tick();
    chk("full deq count", 32'(count_out), 32'd7);
    chk("full deq inst_req", 32'(inst_req), 32'd1);
    deq_ready = 0; tick();
    chk("refill count", 32'(count_out), 32'd8);

    // Pause: everything holds even with responses and consumer ready
    rdy_in = 0; deq_ready = 1; clear = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("pause count", 32'(count_out), 32'd8);
    chk("pause pc", pc_out, 32'd36);
    chk("pause head", deq_pc, 32'd4);
    rdy_in = 1;

    // Drain to 5, then flush with everything else asserted
    inst_ready = 0; deq_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("pre-clear count", 32'(count_out), 32'd5);
    clear = 1; clear_pc = 32'h80; inst_ready = 1; stall_end = 1; jalr_addr = 32'h999;
    tick();
    idle();
    chk("clear count", 32'(count_out), 32'd0);
    chk("clear pc", pc_out, 32'h80);
    chk("clear deq_valid", 32'(deq_valid), 32'd0);

    // JALR stall, drain while stalled, resume on stall_end
    clear = 1; clear_pc = 32'h100; tick(); clear = 0;
    inst_ready = 1; inst = JALR; tick();
    chk("jalr stall_out", 32'(stall_out), 32'd1);
    chk("jalr inst_req", 32'(inst_req), 32'd0);
    inst = ADDI; deq_ready = 1; tick();
    chk("stall drain count", 32'(count_out), 32'd0);
    deq_ready = 0; stall_end = 1; jalr_addr = 32'h200; tick();
    chk("resume pc", pc_out, 32'h200);
    chk("resume stall_out", 32'(stall_out), 32'd0);
    chk("resume inst_req", 32'(inst_req), 32'd1);
    inst_ready = 0; jalr_addr = 32'h300; tick(); // stall_end in FETCH ignored
    chk("stray stall_end pc", pc_out, 32'h200);
    stall_end = 0;

    // Asynchronous reset in the middle of traffic
    inst_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    idle();
    #2 rst_n_in = 0;
    #1;
    chk("async rst count", 32'(count_out), 32'd0);
    chk("async rst pc", pc_out, 32'h0);
    chk("async rst deq_valid", 32'(deq_valid), 32'd0);
    mq.delete(); m_pc = 32'h0; m_stall = 0;
    #1 rst_n_in = 1;
    @(posedge clk_in); #1;

    // Predecode table, both prediction modes side by side
    foreach (vt[k]) begin
      idle(); clear = 1; clear_pc = vt[k].pc; tick();
      clear = 0; inst_ready = 1; inst = vt[k].inst; tick();
      inst_ready = 0;
      chk($sformatf("vec%0d deq_pc", k), deq_pc, vt[k].pc);
      chk($sformatf("vec%0d deq_inst", k), deq_inst, vt[k].inst);
      chk($sformatf("vec%0d pred_bt", k), 32'(deq_pred), 32'(vt[k].pred_bt));
      chk($sformatf("vec%0d next_bt", k), pc_out, vt[k].nxt_bt);
      chk($sformatf("vec%0d stall", k), 32'(stall_out), 32'(vt[k].stall));
      chk($sformatf("vec%0d pred_nt", k), 32'(deq_pred_nt), 32'(vt[k].pred_nt));
      chk($sformatf("vec%0d next_nt", k), pc_out_nt, vt[k].nxt_nt);
    end

    // Randomized traffic against the model
    idle(); clear = 1; clear_pc = 32'h400; tick(); clear = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      int          kind;
      r    = $urandom();
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1:    r[6:0] = 7'h6F;
        2, 3, 4: r[6:0] = 7'h63;
        5:       r[6:0] = 7'h67;
        default: r[6:0] = 7'h13;
      endcase
      inst       = r;
      rdy_in     = ($urandom_range(0, 9) != 0);
      inst_ready = ($urandom_range(0, 9) < 7);
      deq_ready  = ($urandom_range(0, 1) == 1);
      clear      = ($urandom_range(0, 49) == 0);
      clear_pc   = {$urandom(), 2'b00};
      stall_end  = ($urandom_range(0, 4) == 0);
      jalr_addr  = {$urandom(), 2'b00};
      tick();
    end
    idle();
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor of the front-end fetch/issue unit.
- Decouples instruction fetch from issue with a DEPTH-entry instruction queue, so fetch keeps prefetching while RS/LSB/ROB are full.
- Computes the next PC with a built-in predecode and a selectable static branch-prediction mode.
- Handles JALR stall/resume and ROB clear (flush) redirects; sits between memory_unit (icache port) and the downstream decoder/issue logic.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 2.
- PTR_BIT, 3, log2(DEPTH).
- RESET_PC, 32'h0, PC loaded on reset.
- PRED_MODE, 1, 0 = always not-taken; 1 = BTFN (backward branch taken, forward branch not taken).

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  global pause; no state change while low.
- inst_req  output  1  fetch request to memory_unit.
- pc_out  output  32  fetch address; held stable while inst_req=1 and inst_ready=0.
- inst_ready  input  1  memory_unit returns the instruction at pc_out this cycle.
- inst  input  32  fetched instruction word.
- deq_valid  output  1  queue head valid.
- deq_inst  output  32  head instruction.
- deq_pc  output  32  head instruction address.
- deq_pred  output  1  head was predicted taken (JAL or taken branch).
- deq_ready  input  1  consumer takes the head this cycle.
- clear  input  1  flush from ROB.
- clear_pc  input  32  redirect target on clear.
- stall_end  input  1  JALR target resolved.
- jalr_addr  input  32  JALR target.
- stall_out  output  1  high in STALL state.
- count_out  output  PTR_BIT+1  number of occupied entries.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - pc <= RESET_PC; head/tail/count <= 0; state <= FETCH.
  - Resulting outputs: inst_req=1, pc_out=RESET_PC, deq_valid=0, stall_out=0, count_out=0.
- States:
  - FETCH: fetch is active. Moves to STALL when a JALR is enqueued.
  - STALL: fetch halted. Moves to FETCH on stall_end.
- inst_req = (state==FETCH) && (count != DEPTH). Combinational; does not depend on same-cycle deq_ready.
- Fetch acceptance: when rdy_in && inst_req && inst_ready && !clear:
  - Enqueue {inst, pc, pred} at tail; pc <= next_pc.
- Predecode, on opcode inst[6:0]; all adds are 32-bit modulo 2^32:
  - 1101111 (JAL): next_pc = pc + J-imm (sign-extended); pred = 1.
  - 1100011 (branch): when PRED_MODE==1 and inst[31]==1, next_pc = pc + B-imm and pred = 1. Otherwise next_pc = pc + 4 and pred = 0.
  - 1100111 (JALR): enqueue; next_pc = pc + 4 (unused); pred = 0; state <= STALL.
  - Any other opcode: next_pc = pc + 4; pred = 0.
- Dequeue:
  - deq_valid = (count != 0); deq_* driven combinationally from the head entry.
  - When rdy_in && deq_valid && deq_ready, head advances.
- Count update: enqueue and dequeue in the same cycle leave count unchanged. Head/tail pointers wrap modulo DEPTH.
- Full queue: inst_req low; pc_out held; the next fetch is requested the cycle after count drops.
- Empty queue: deq_ready ignored; no underflow.
- STALL:
  - stall_end: pc <= jalr_addr, state <= FETCH, so inst_req may rise the following cycle.
  - stall_end while in FETCH is ignored.
  - Queue continues to drain.
- clear, which has priority over all other events in the cycle:
  - Queue emptied (head=tail=count=0); pc <= clear_pc; state <= FETCH.
  - Any same-cycle inst_ready response, dequeue and stall_end are discarded.
- rdy_in low: all registers hold; inst_ready and deq_ready are ignored. The memory side must re-present its response.
- Mid-operation asynchronous reset overrides everything immediately; no partial entry survives.

Decomposition:
- Shared const.v additions:
  - opcode constants OPC_JAL, OPC_BRANCH, OPC_JALR.
  - FQ_DEPTH_DEFAULT.
  - PRED_NT / PRED_BTFN mode codes.
- One combinational sub-module, fetch_predecode:
  - Inputs: inst, pc, PRED_MODE.
  - Outputs: next_pc, pred, is_jalr.
  - Instantiated once; the queue storage stays in the parent.

Test Plan:
- Reset release, memory always ready with ADDI words, deq_ready=0 → 8 enqueues at pc 0,4,…,28; count_out=8; inst_req=0; pc_out holds 32.
- JAL at pc 0x10 with imm +0x20 → entry deq_pc=0x10, deq_pred=1; next pc_out=0x30.
- PRED_MODE=1: BEQ at 0x40 with imm −8 gives pred=1, next pc 0x38; BEQ at 0x38 with imm +8 gives pred=0, next pc 0x3C. PRED_MODE=0: both give pred=0.
- JALR at 0x100 → stall_out=1, inst_req=0; the queue still drains. stall_end with jalr_addr=0x200 → next cycle pc_out=0x200, stall_out=0.
- Queue holds 5 entries; clear with clear_pc=0x80 asserted with inst_ready=1 and deq_ready=1 → next cycle count_out=0, pc_out=0x80, no entry written.
- Full queue with simultaneous deq → count 8→7, inst_req rises next cycle. rdy_in=0 for 3 cycles → count, pc and head unchanged.
